// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Requests arrive on valid/ready channels and are granted round-robin.
// The winner's operands are registered and drive the ALU for one cycle.
// The ALU result and flags are then captured. They are returned on the
// granted requester's response channel until that requester accepts them.
//
// Ports:
//   clk, reset               clock; synchronous active-low reset
//   req{0,1}_valid/ready     request handshake per requester
//   req{0,1}_ctrl/a/b/cin    ALU control code, operands, carry-in
//   rsp{0,1}_valid/ready     response handshake per requester
//   rsp_result, rsp_flags    captured ALUResult / ALUFlags {N,Z,C,V}
//   alu_a/b/ctrl/cin         to the ALU (registered operands only)
//   alu_result, alu_flags    from the ALU
//   busy                     high whenever an operation is in flight
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             grant_id;
  logic             grant;
  logic             accept;
  logic [2:0]       op_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             rsp0_q;
  logic             rsp1_q;

  // Round-robin: on contention the requester that did not win last time
  // wins now; otherwise the only valid requester wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  // Readies are combinational on the valids. They are gated by reset so
  // that nothing is accepted while reset is held.
  assign accept     = reset && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // The ALU sees only registered operands, never the request ports.
  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_ctrl = op_ctrl;
  assign alu_cin  = op_cin;

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      op_ctrl    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            grant_id   <= grant;
            last_grant <= grant;
            op_ctrl    <= grant ? req1_ctrl : req0_ctrl;
            op_a       <= grant ? req1_a    : req0_a;
            op_b       <= grant ? req1_b    : req0_b;
            op_cin     <= grant ? req1_cin  : req0_cin;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // The ALU has had a full cycle to settle on the operand registers.
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp0_q     <= !grant_id;
          rsp1_q     <= grant_id;
          state      <= RESP;
        end
        RESP: begin
          if (grant_id ? rsp1_ready : rsp0_ready) begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. It provides a stand-in combinational ALU and a
// transaction-level model of the arbiter that is checked every cycle. It
// also runs directed vectors with hand-computed expectations.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_cin;
  logic [2:0]   req0_ctrl;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [2:0]   req1_ctrl;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctrl;
  logic         alu_cin;
  logic [3:0]   alu_flags;
  logic         busy;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
  );

  // Stand-in ALU: 000 add with carry-in, 001 subtract, 010 and, 011 or,
  // others xor. Returns {N,Z,C,V, result}.
  function automatic logic [W+3:0] alu_fn(input logic [2:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] r, bo;
    logic         cy, v;
    s = '0; bo = b; cy = 1'b0; v = 1'b0;
    case (c)
      3'b000: s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      3'b001: begin bo = ~b; s = {1'b0, a} + {1'b0, bo} + 33'd1; end
      default: s = '0;
    endcase
    case (c)
      3'b000, 3'b001: begin
        r  = s[W-1:0];
        cy = s[W];
        v  = (a[W-1] == bo[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      default: r = a ^ b;
    endcase
    return {r[W-1], (r == '0), cy, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b, alu_cin);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: one operation in flight at most. Its response
  // is due two cycles after acceptance and retires when its requester is ready.
  logic         chk_en = 1'b0;
  int           cyc = 0;
  logic         m_busy = 1'b0, m_who = 1'b0, m_last = 1'b1;
  logic [2:0]   m_ctrl = '0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic         m_cin = 1'b0;
  logic [3:0]   m_flg = '0;
  int           m_acc = 0;

  always @(negedge clk) begin
    logic g, e0, e1, v;
    logic [W+3:0] fr;
    cyc++;
    if (chk_en) begin
      g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      e0 = reset && !m_busy && (req0_valid || req1_valid) && !g;
      e1 = reset && !m_busy && (req0_valid || req1_valid) && g;
      v  = m_busy && (cyc >= m_acc + 2);
      check("req0_ready", 32'(req0_ready), 32'(e0));
      check("req1_ready", 32'(req1_ready), 32'(e1));
      check("rsp0_valid", 32'(rsp0_valid), 32'(v && !m_who));
      check("rsp1_valid", 32'(rsp1_valid), 32'(v && m_who));
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_result", rsp_result, m_res);
      check("rsp_flags", 32'(rsp_flags), 32'(m_flg));
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      check("alu_cin", 32'(alu_cin), 32'(m_cin));
      if (!reset) begin
        m_busy = 1'b0; m_who = 1'b0; m_last = 1'b1;
        m_ctrl = '0; m_a = '0; m_b = '0; m_cin = 1'b0; m_res = '0; m_flg = '0;
      end else if (!m_busy) begin
        if (e0 || e1) begin
          m_busy = 1'b1; m_who = g; m_last = g; m_acc = cyc;
          m_ctrl = g ? req1_ctrl : req0_ctrl;
          m_a    = g ? req1_a    : req0_a;
          m_b    = g ? req1_b    : req0_b;
          m_cin  = g ? req1_cin  : req0_cin;
        end
      end else if (cyc == m_acc + 1) begin
        fr = alu_fn(m_ctrl, m_a, m_b, m_cin);
        m_res = fr[W-1:0];
        m_flg = fr[W+3:W];
      end else if (v && (m_who ? rsp1_ready : rsp0_ready)) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  int gseq[8];
  int gn, nrsp;

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    do_reset();
    chk_en = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", rsp_result, 32'd0);

    // 1: single ADD on requester 0
    tick();
    req0_valid = 1'b1; req0_ctrl = 3'b000; req0_a = 32'h5; req0_b = 32'h3; req0_cin = 1'b0;
    #1;
    check("t1_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t1_issue_rsp0", 32'(rsp0_valid), 32'd0);
    tick();
    #1;
    check("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("t1_result", rsp_result, 32'h8);
    check("t1_flags", 32'(rsp_flags), 32'h0);
    tick();

    // 2: contention straight out of reset
    do_reset();
    req0_valid = 1'b1; req0_a = 32'h1;  req0_b = 32'h2;
    req1_valid = 1'b1; req1_ctrl = 3'b000; req1_a = 32'd100; req1_b = 32'd200;
    #1;
    check("t2_req0_ready", 32'(req0_ready), 32'd1);
    check("t2_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    #1;
    check("t2_next_req1_ready", 32'(req1_ready), 32'd1);
    check("t2_next_req0_ready", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();

    // 3: continuous contention, responses always accepted
    req0_valid = 1'b1; req0_ctrl = 3'b000; req0_a = 32'd10; req0_b = 32'd20; req0_cin = 1'b1;
    req1_valid = 1'b1; req1_ctrl = 3'b011; req1_a = 32'hF0; req1_b = 32'h0F;
    gn = 0; nrsp = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready && gn < 8) begin gseq[gn] = 0; gn++; end
      if (req1_ready && gn < 8) begin gseq[gn] = 1; gn++; end
      if (rsp0_valid || rsp1_valid) nrsp++;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t3_grant_count", 32'(gn), 32'd4);
    check("t3_grant_order", {28'd0, 4'(gseq[0]), 4'(gseq[1]), 4'(gseq[2]), 4'(gseq[3])} & 32'hFFFF,
          32'h0101);
    check("t3_rsp_count", 32'(nrsp), 32'd4);

    // 4: backpressure on requester 1
    req1_valid = 1'b1; req1_ctrl = 3'b001; req1_a = 32'h5; req1_b = 32'h5; req1_cin = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    check("t4_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ctrl = 3'b000; req0_a = 32'h7; req0_b = 32'h8; req0_cin = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("t4_result", rsp_result, 32'h0);
      check("t4_flags", 32'(rsp_flags), 32'h6);
      check("t4_req0_ready", 32'(req0_ready), 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    #1;
    check("t4_req0_after", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();

    // 5: reset during ISSUE drops the operation
    req0_valid = 1'b1; req0_a = 32'h9; req0_b = 32'h9;
    tick();
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rsp0", 32'(rsp0_valid), 32'd0);
    check("t5_rsp1", 32'(rsp1_valid), 32'd0);
    check("t5_result", rsp_result, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      tick();
    end

    // 6: request-port operands change after acceptance
    req0_valid = 1'b1; req0_ctrl = 3'b000; req0_a = 32'h1234; req0_b = 32'h10; req0_cin = 1'b0;
    tick();
    req0_valid = 1'b0;
    req0_a = $urandom; req1_a = $urandom;
    #1;
    check("t6_alu_a_issue", alu_a, 32'h1234);
    tick();
    req0_a = $urandom; req1_a = $urandom;
    #1;
    check("t6_alu_a_resp", alu_a, 32'h1234);
    check("t6_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t6_result", rsp_result, 32'h1244);
    tick();
    req0_a = $urandom; req1_a = $urandom;
    #1;
    check("t6_alu_a_idle", alu_a, 32'h1234);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two independent requesters, e.g. an execute-stage port and a debug/address-generation port.
- Accepts requests on valid/ready channels and grants them round-robin.
- Registers the operands, drives the ALU for one cycle, captures the result and flags, and returns them on the granted requester's response channel.
- Sits between the requesters and the `alu` instance; the `alu` ports (SrcA, SrcB, ALUControl, carry, ALUResult, ALUFlags) connect 1:1 to the alu_* ports below.

Parameters:
- WIDTH, 32, operand/result width; must match the alu instance.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_ctrl  in  3  ALUControl code for requester 0
- req0_a, req0_b  in  WIDTH  operands for requester 0
- req0_cin  in  1  carry-in for requester 0
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b, req1_cin  same as above, for requester 1
- rsp0_valid  out  1  response for requester 0 present
- rsp0_ready  in  1  requester 0 accepts response
- rsp1_valid  out  1  response for requester 1 present
- rsp1_ready  in  1  requester 1 accepts response
- rsp_result  out  WIDTH  captured ALUResult, shared by both responses
- rsp_flags  out  4  captured ALUFlags {N,Z,C,V}, shared by both responses
- alu_a, alu_b  out  WIDTH  to alu SrcA/SrcB
- alu_ctrl  out  3  to alu ALUControl
- alu_cin  out  1  to alu carry
- alu_result  in  WIDTH  from alu ALUResult
- alu_flags  in  4  from alu ALUFlags
- busy  out  1  high whenever state != IDLE

Behaviour:

States and transitions:
- IDLE:
  - Computes a grant from the req valids.
  - If any valid is high, asserts the granted reqN_ready combinationally, latches that requester's ctrl/a/b/cin into operand registers, records the grant id, and moves to ISSUE.
  - Otherwise stays in IDLE.
- ISSUE: lasts exactly one cycle. The alu settles on the operand registers; at the clock edge alu_result/alu_flags are captured into rsp_result/rsp_flags. Moves to RESP.
- RESP:
  - Asserts rspN_valid for the recorded grant id only.
  - Holds rsp_result/rsp_flags stable.
  - On rspN_ready high, moves to IDLE; otherwise stays in RESP indefinitely.

Ready and grant rules:
- reqN_ready is high only in IDLE, only for the granted requester, and never for both in the same cycle.
- reqN_ready may depend combinationally on reqN_valid.
- Round-robin: last_grant register.
  - If both valid: grant = ~last_grant.
  - If one valid: grant goes to that one.
- last_grant updates on every accepted request.

ALU drive and response data:
- alu_a/alu_b/alu_ctrl/alu_cin are driven directly from the operand registers in every state; there is no combinational path from the req ports to the alu.
- rsp_result and rsp_flags change only at the ISSUE->RESP edge.
- Latency: request accepted at edge T; rspN_valid is high from T+2. Minimum 3 cycles per operation.
- No new request is accepted while in ISSUE or RESP. A requester holding valid keeps its request pending.
- A response completes on the same edge that rspN_ready is seen. The next IDLE cycle may accept a new request, including from the same requester if the other requester is idle.

Reset (reset==0 at a rising edge, from any state including ISSUE or RESP):
- State goes to IDLE; an in-flight operation is dropped without a response.
- Operand registers, rsp_result and rsp_flags go to 0; grant id goes to 0.
- last_grant goes to 1, so requester 0 wins the first contention.
- All ready and valid outputs are 0 and busy is 0 while reset is held.

Arithmetic: none inside this block. Width, carry and flag semantics are entirely the alu's; the arbiter passes and captures values unmodified.

Test Plan:
1. Single request on 0: ctrl=000 (ADD), a=0x00000005, b=0x00000003, cin=0. Required: rsp0_valid at T+2, rsp_result=0x00000008, rsp_flags=0000, rsp1_valid stays 0.
2. Contention out of reset: both valid in the same cycle. Requester 0 gets the first grant (req0_ready high, req1_ready low). Requester 1 gets the grant in the next IDLE cycle.
3. Both valid continuously, rsp ready always 1. Required: grants alternate 0,1,0,1; one response every 3 cycles.
4. Backpressure: requester 1, ctrl=001 (SUB), a=b=0x00000005, rsp1_ready held 0 for 5 cycles. Required: rsp1_valid stays high with rsp_result=0x00000000, rsp_flags=0110 (Z, C set for no borrow), held stable. req0_ready stays 0 throughout.
5. Reset mid-operation: reset=0 during ISSUE. Required: next cycle busy=0, rsp0_valid=rsp1_valid=0, rsp_result=0. No response is emitted after reset is released.
6. Operand isolation: after req0 is accepted, change req0_a/req1_a every cycle. Required: alu_a and rsp_result reflect only the latched operands.
